fetch_stage: RTL and testbench

//  Instruction fetch stage feeding decode: holds the PC and issues in-order word fetches to the

---
 rtl/fetch_stage.sv | 129 ++++++++++++
 tb/tb_fetch_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, credit-limited imem requests, in-order response FIFO feeding decode.
// Optional macro FETCH_BYPASS_EN lets a response reach decode in the same cycle when the FIFO is empty.
module fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Handshake: a request transfers on a rising edge where imem_req_valid && imem_req_ready;
  // imem_addr stays stable while valid is high and ready is low. Responses have no backpressure.

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_discard;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [31:0]     r_instr_q [DEPTH];
  logic [XLEN-1:0] r_pc_q    [DEPTH];

  logic            w_credit;
  logic            w_accept;
  logic            w_drop;
  logic            w_bypass;
  logic            w_consume;
  logic            w_push;
  logic            w_pop;
  logic            w_head_valid;
  logic [XLEN-1:0] w_redirect_pc;

  // Credit covers both in-flight words and buffered words so the FIFO can never overflow.
  assign w_credit       = ({1'b0, r_outstanding} + {1'b0, r_count}) < (CW + 1)'(DEPTH);
  assign imem_req_valid = reset & ~redirect_valid & w_credit;
  assign imem_addr      = r_fetch_pc;
  assign w_accept       = imem_req_valid & imem_req_ready;
  assign w_redirect_pc  = redirect_pc & ~XLEN'(3);

  assign w_drop       = imem_rsp_valid & (redirect_valid | (r_discard != '0));
  assign w_head_valid = (r_count != '0);

`ifdef FETCH_BYPASS_EN
  assign w_bypass  = imem_rsp_valid & ~w_head_valid & (r_discard == '0) & ~redirect_valid;
  assign w_consume = w_bypass & ~stall;
`else
  assign w_bypass  = 1'b0;
  assign w_consume = 1'b0;
`endif

  assign w_push = imem_rsp_valid & ~w_drop & ~w_consume;
  assign w_pop  = w_head_valid & ~stall & ~redirect_valid;

  always_comb begin
    id_valid = w_head_valid | w_bypass;
    id_instr = NOP;
    id_pc    = '0;
    if (w_head_valid) begin
      id_instr = r_instr_q[r_rd_ptr];
      id_pc    = r_pc_q[r_rd_ptr];
    end else if (w_bypass) begin
      id_instr = imem_rsp_data;
      id_pc    = r_rsp_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight after this edge is stale and must be dropped.
      r_fetch_pc    <= w_redirect_pc;
      r_rsp_pc      <= w_redirect_pc;
      r_outstanding <= r_outstanding - CW'(imem_rsp_valid);
      r_discard     <= r_outstanding - CW'(imem_rsp_valid);
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
    end else begin
      if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
      end
      r_outstanding <= r_outstanding + CW'(w_accept) - CW'(imem_rsp_valid);
      r_discard     <= r_discard - CW'(w_drop);
      if (w_push | w_consume) begin
        r_rsp_pc <= r_rsp_pc + XLEN'(4);
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage needs no reset; r_count qualifies every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_q[r_wr_ptr] <= imem_rsp_data;
      r_pc_q[r_wr_ptr]    <= r_rsp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: table-driven cycle vectors against a latency-configurable imem model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        rd;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_idv;
    logic [31:0] e_pc;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  vec_t        vecs[$];
  pend_t       pend[$];
  logic [31:0] exp_q[$];
  int          cyc = 0;
  int          lat = 1;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  function automatic vec_t v(input logic st, input logic rd, input logic [31:0] rpc,
                             input logic rdy, input logic e_req, input logic [31:0] e_addr,
                             input logic e_idv, input logic [31:0] e_pc);
    vec_t r;
    r.st = st; r.rd = rd; r.rpc = rpc; r.rdy = rdy;
    r.e_req = e_req; r.e_addr = e_addr; r.e_idv = e_idv; r.e_pc = e_pc;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge; the imem model answers in order after lat cycles.
  task automatic drive(input logic st, input logic rd, input logic [31:0] rpc, input logic rdy);
    stall          = st;
    redirect_valid = rd;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = imem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #2;
  endtask

  task automatic advance();
    pend_t p;
    if (imem_req_valid && imem_req_ready) begin
      p.addr = imem_addr;
      p.due  = cyc + lat;
      pend.push_back(p);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_valid"}, {31'd0, imem_req_valid}, 32'd0);
    check({tag, " addr"}, imem_addr, 32'h0000_0000);
    check({tag, " id_valid"}, {31'd0, id_valid}, 32'd0);
    check({tag, " id_instr"}, id_instr, NOP);
    check({tag, " id_pc"}, id_pc, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    pend.delete();
    repeat (2) @(negedge clk);
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
  endtask

  task automatic apply(input string tag);
    logic [31:0] e_instr;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].st, vecs[i].rd, vecs[i].rpc, vecs[i].rdy);
      e_instr = vecs[i].e_idv ? imem_word(vecs[i].e_pc) : NOP;
      check($sformatf("%s[%0d] req_valid", tag, i), {31'd0, imem_req_valid}, {31'd0, vecs[i].e_req});
      check($sformatf("%s[%0d] addr", tag, i), imem_addr, vecs[i].e_addr);
      check($sformatf("%s[%0d] id_valid", tag, i), {31'd0, id_valid}, {31'd0, vecs[i].e_idv});
      check($sformatf("%s[%0d] id_pc", tag, i), id_pc, vecs[i].e_idv ? vecs[i].e_pc : 32'd0);
      check($sformatf("%s[%0d] id_instr", tag, i), id_instr, e_instr);
      if (id_valid && !stall && exp_q.size() > 0) begin
        check($sformatf("%s[%0d] delivered pc", tag, i), id_pc, exp_q.pop_front());
      end
      advance();
    end
    vecs.delete();
  endtask

  task automatic load_a();
`ifdef FETCH_BYPASS_EN
    vecs.push_back(v(0, 0, 0, 1, 1, 32'h00, 0, 32'h00));
    vecs.push_back(v(0, 0, 0, 1, 1, 32'h04, 1, 32'h00));
    vecs.push_back(v(0, 0, 0, 1, 1, 32'h08, 1, 32'h04));
    vecs.push_back(v(0, 0, 0, 1, 1, 32'h0C, 1, 32'h08));
    vecs.push_back(v(0, 0, 0, 1, 1, 32'h10, 1, 32'h0C));
`else
    vecs.push_back(v(0, 0, 0, 1, 1, 32'h00, 0, 32'h00));
    vecs.push_back(v(0, 0, 0, 1, 1, 32'h04, 0, 32'h00));
    vecs.push_back(v(0, 0, 0, 1, 0, 32'h08, 1, 32'h00));
    vecs.push_back(v(0, 0, 0, 1, 1, 32'h08, 1, 32'h04));
    vecs.push_back(v(0, 0, 0, 1, 1, 32'h0C, 0, 32'h00));
    vecs.push_back(v(0, 0, 0, 1, 0, 32'h10, 1, 32'h08));
    vecs.push_back(v(0, 0, 0, 1, 1, 32'h10, 1, 32'h0C));
    vecs.push_back(v(0, 0, 0, 1, 1, 32'h14, 0, 32'h00));
`endif
  endtask

  initial begin
    do_reset();
    lat = 1;
    load_a();
    apply("flow");

`ifndef FETCH_BYPASS_EN
    // Decode stall for five cycles with a full buffer, then in-order drain.
    do_reset();
    lat = 1;
    exp_q = '{32'h0, 32'h4, 32'h8};
    vecs.push_back(v(0, 0, 0, 1, 1, 32'h00, 0, 32'h0));
    vecs.push_back(v(0, 0, 0, 1, 1, 32'h04, 0, 32'h0));
    for (int k = 0; k < 5; k++) vecs.push_back(v(1, 0, 0, 1, 0, 32'h08, 1, 32'h0));
    vecs.push_back(v(0, 0, 0, 1, 0, 32'h08, 1, 32'h0));
    vecs.push_back(v(0, 0, 0, 1, 1, 32'h08, 1, 32'h4));
    vecs.push_back(v(0, 0, 0, 1, 1, 32'h0C, 0, 32'h0));
    vecs.push_back(v(0, 0, 0, 1, 0, 32'h10, 1, 32'h8));
    apply("stall");
    check("stall drained", exp_q.size(), 32'd0);

    // Redirect to 0x100 with two requests in flight (imem latency 3).
    do_reset();
    lat = 3;
    vecs.push_back(v(0, 0, 0,      1, 1, 32'h000, 0, 32'h0));
    vecs.push_back(v(0, 0, 0,      1, 1, 32'h004, 0, 32'h0));
    vecs.push_back(v(0, 1, 32'h100, 1, 0, 32'h008, 0, 32'h0));
    vecs.push_back(v(0, 0, 0,      1, 0, 32'h100, 0, 32'h0));
    vecs.push_back(v(0, 0, 0,      1, 1, 32'h100, 0, 32'h0));
    vecs.push_back(v(0, 0, 0,      1, 1, 32'h104, 0, 32'h0));
    vecs.push_back(v(0, 0, 0,      1, 0, 32'h108, 0, 32'h0));
    vecs.push_back(v(0, 0, 0,      1, 0, 32'h108, 0, 32'h0));
    vecs.push_back(v(0, 0, 0,      1, 0, 32'h108, 1, 32'h100));
    vecs.push_back(v(0, 0, 0,      1, 1, 32'h108, 1, 32'h104));
    apply("redir");

    // Redirect while stalled, with a buffered head and a response arriving in the same cycle.
    do_reset();
    lat = 1;
    vecs.push_back(v(0, 0, 0,      1, 1, 32'h000, 0, 32'h0));
    vecs.push_back(v(0, 0, 0,      1, 1, 32'h004, 0, 32'h0));
    vecs.push_back(v(1, 1, 32'h200, 1, 0, 32'h008, 1, 32'h0));
    vecs.push_back(v(1, 0, 0,      1, 1, 32'h200, 0, 32'h0));
    vecs.push_back(v(1, 0, 0,      1, 1, 32'h204, 0, 32'h0));
    vecs.push_back(v(0, 0, 0,      1, 0, 32'h208, 1, 32'h200));
    vecs.push_back(v(0, 0, 0,      1, 1, 32'h208, 1, 32'h204));
    apply("redir_stall");

    // Redirect near the top of the address space; low target bits must be ignored.
    do_reset();
    lat = 1;
    vecs.push_back(v(0, 1, 32'hFFFF_FFFF, 1, 0, 32'h0000_0000, 0, 32'h0));
    vecs.push_back(v(0, 0, 0,             1, 1, 32'hFFFF_FFFC, 0, 32'h0));
    vecs.push_back(v(0, 0, 0,             1, 1, 32'h0000_0000, 0, 32'h0));
    vecs.push_back(v(0, 0, 0,             1, 0, 32'h0000_0004, 1, 32'hFFFF_FFFC));
    vecs.push_back(v(0, 0, 0,             1, 1, 32'h0000_0004, 1, 32'h0000_0000));
    apply("wrap");

    // imem not ready: address must hold until accepted.
    do_reset();
    lat = 1;
    vecs.push_back(v(0, 0, 0, 0, 1, 32'h00, 0, 32'h0));
    vecs.push_back(v(0, 0, 0, 0, 1, 32'h00, 0, 32'h0));
    vecs.push_back(v(0, 0, 0, 1, 1, 32'h00, 0, 32'h0));
    vecs.push_back(v(0, 0, 0, 1, 1, 32'h04, 0, 32'h0));
    vecs.push_back(v(0, 0, 0, 1, 0, 32'h08, 1, 32'h0));
    apply("backpressure");

    // Asynchronous reset mid-stream with words in flight and a valid head.
    do_reset();
    lat = 3;
    vecs.push_back(v(0, 0, 0, 1, 1, 32'h00, 0, 32'h0));
    vecs.push_back(v(0, 0, 0, 1, 1, 32'h04, 0, 32'h0));
    vecs.push_back(v(0, 0, 0, 1, 0, 32'h08, 0, 32'h0));
    vecs.push_back(v(0, 0, 0, 1, 0, 32'h08, 0, 32'h0));
    apply("pre_reset");
    drive(0, 0, 0, 1);
    check("pre_reset id_valid", {31'd0, id_valid}, 32'd1);
    check("pre_reset id_pc", id_pc, 32'h0);
    #1;
    reset = 1'b0;
    #1;
    check_reset_outputs("async_reset");
`endif

    // Restart from RESET_PC after reset.
    do_reset();
    lat = 1;
    load_a();
    apply("refetch");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
